// File: rtl/accel_mmio_bridge_pkg.sv
// Shared definitions for the accelerator MMIO bridge.
//   - register offsets (word index, addr[4:2])
//   - CTRL / IRQSTAT bit positions
//   - default FIFO depth
package accel_pkg;

   typedef enum logic [2:0] {
      REG_CTRL    = 3'd0,
      REG_STATUS  = 3'd1,
      REG_DIN     = 3'd2,
      REG_DOUT    = 3'd3,
      REG_IRQSTAT = 3'd4
   } reg_e;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_CLR    = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int IRQ_OVF   = 0;
   localparam int IRQ_UDF   = 1;
   localparam int IRQ_AVAIL = 2;

   localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/accel_mmio_bridge_if.sv
// CPU-side memory bus of the accelerator bridge.
//   master : CPU / interconnect (drives valid, wstrb, addr, wdata)
//   slave  : bridge (drives ready, rdata)
interface accel_mmio_bridge_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/accel_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with show-ahead head.
//   clk, resetn   : clock, async active-low reset
//   clr           : synchronous flush, dominates push/pop
//   push, wdata   : write side; accepted when not full or when popping
//   pop, rdata    : read side; rdata is the current head, pop ignored when empty
//   full, empty, level : occupancy
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign level   = cnt;
   assign rdata   = mem[rd_ptr];
   // a pop frees the slot, so a full FIFO can take a push in the same cycle
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
         else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
      end
   end

   // storage needs no reset; occupancy state guards every read
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/accel_mmio_bridge.sv
// MMIO front end for the data-processing accelerator.
//   clk, resetn        : clock, async active-low reset
//   bus (slave)        : CPU word bus, one wait cycle per access
//   m_valid/ready/data : word stream to the core (from DATA_IN writes)
//   s_valid/ready/data : result stream from the core (read via DATA_OUT)
//   irq                : level interrupt, registered
module accel_mmio_bridge
   import accel_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DATA_W     = 32
) (
   input  logic               clk,
   input  logic               resetn,
   accel_mmio_bridge_if.slave bus,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DATA_W-1:0]  m_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   output logic               irq
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic              ready_q;
   logic [31:0]       rdata_q, rd_val;
   logic              en, irq_en, ovf, udf;
   logic [2:0]        ra;
   logic              acc, wr, rd;
   logic              wr_ctrl, wr_din, wr_irq, rd_dout, clr;
   logic              in_full, in_empty, out_full, out_empty;
   logic [LW-1:0]     in_level, out_level;
   logic              in_pop, out_push;
   logic [DATA_W-1:0] out_head;
   logic              unused_addr;

   assign unused_addr = ^{bus.iomem_addr[31:5], bus.iomem_addr[1:0]};

   // acc is the single cycle whose edge raises ready: all side effects happen here
   assign ra      = bus.iomem_addr[4:2];
   assign acc     = bus.iomem_valid && !ready_q;
   assign wr      = acc && (bus.iomem_wstrb != 4'h0);
   assign rd      = acc && (bus.iomem_wstrb == 4'h0);
   assign wr_ctrl = wr && (ra == REG_CTRL);
   assign wr_din  = wr && (ra == REG_DIN);
   assign wr_irq  = wr && (ra == REG_IRQSTAT);
   assign rd_dout = rd && (ra == REG_DOUT);
   assign clr     = wr_ctrl && bus.iomem_wdata[CTRL_CLR];

   assign m_valid  = en && !in_empty;
   assign s_ready  = en && !out_full;
   assign in_pop   = m_valid && m_ready;
   assign out_push = s_valid && s_ready;

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_in_fifo (
      .clk(clk), .resetn(resetn), .clr(clr),
      .push(wr_din), .wdata(bus.iomem_wdata),
      .pop(in_pop), .rdata(m_data),
      .full(in_full), .empty(in_empty), .level(in_level)
   );

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_out_fifo (
      .clk(clk), .resetn(resetn), .clr(clr),
      .push(out_push), .wdata(s_data),
      .pop(rd_dout), .rdata(out_head),
      .full(out_full), .empty(out_empty), .level(out_level)
   );

   always_comb begin
      rd_val = '0;
      case (ra)
         REG_CTRL:    rd_val = {29'd0, irq_en, 1'b0, en};
         REG_STATUS:  rd_val = {12'd0, 4'(out_level), 4'd0, 4'(in_level),
                                4'd0, out_full, out_empty, in_full, in_empty};
         REG_DOUT:    rd_val = out_empty ? '0 : out_head;
         REG_IRQSTAT: rd_val = {29'd0, !out_empty, udf, ovf};
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         en      <= 1'b0;
         irq_en  <= 1'b0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         irq     <= 1'b0;
      end else begin
         ready_q <= acc;
         rdata_q <= rd ? rd_val : '0;
         if (wr_ctrl) begin
            en     <= bus.iomem_wdata[CTRL_EN];
            irq_en <= bus.iomem_wdata[CTRL_IRQ_EN];
         end
         if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end else begin
            // a write into a full FIFO is only lost if the core is not draining it this cycle
            if (wr_din && in_full && !in_pop)                ovf <= 1'b1;
            else if (wr_irq && bus.iomem_wdata[IRQ_OVF])     ovf <= 1'b0;
            if (rd_dout && out_empty)                        udf <= 1'b1;
            else if (wr_irq && bus.iomem_wdata[IRQ_UDF])     udf <= 1'b0;
         end
         irq <= irq_en && (ovf || udf || !out_empty);
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
endmodule

// File: tb/tb_accel_mmio_bridge.sv
module tb_accel_mmio_bridge;
   import accel_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m_valid, m_ready = 1'b0;
   logic [31:0] m_data;
   logic        s_valid = 1'b0, s_ready;
   logic [31:0] s_data, s_fix = '0, s_cnt = 32'hC000_0000;
   logic        s_auto = 1'b0;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mq[$];   // expected words on the core stream
   logic [31:0] oq[$];   // words the core pushed, expected on DATA_OUT
   logic [31:0] rq[$];   // expected read data of pending bus reads

   accel_mmio_bridge_if bus();

   accel_mmio_bridge #(.FIFO_DEPTH(8), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .irq(irq)
   );

   always #5 clk = ~clk;

   assign s_data = s_auto ? s_cnt : s_fix;
   always @(posedge clk) if (s_auto) s_cnt <= s_cnt + 32'd1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // core stream scoreboard: every accepted word must be the next one written
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         if (mq.size() == 0) chk("m_extra_pop", {31'd0, m_valid}, 32'd0);
         else chk("m_data", m_data, mq.pop_front());
      end
   end

   // record every result word the bridge accepts from the core
   always @(negedge clk) begin
      if (s_valid && s_ready) oq.push_back(s_data);
   end

   task automatic bus_xfer(input logic [2:0] r, input logic [3:0] strb,
                           input logic [31:0] wd, output logic [31:0] rd);
      int n;
      @(posedge clk); #1;
      bus.iomem_addr  = {27'd0, r, 2'b00};
      bus.iomem_wstrb = strb;
      bus.iomem_wdata = wd;
      bus.iomem_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.iomem_ready && n < 8);
      if (!bus.iomem_ready) chk("ack_timeout", {31'd0, bus.iomem_ready}, 32'd1);
      rd = bus.iomem_rdata;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] strb = 4'hF);
      logic [31:0] dummy;
      bus_xfer(r, strb, d, dummy);
   endtask

   task automatic wr_din(input logic [31:0] d, input logic [3:0] strb = 4'hF);
      mq.push_back(d);
      wr(REG_DIN, d, strb);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] r, input logic [31:0] exp);
      logic [31:0] d;
      rq.push_back(exp);
      bus_xfer(r, 4'h0, 32'h0, d);
      chk(tag, d, rq.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
      bus.iomem_addr  = '0;
      bus.iomem_wdata = '0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
      chk("rst_rdata", bus.iomem_rdata, 32'd0);
      chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
      chk("rst_sready", {31'd0, s_ready}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      // ready exactly one cycle after valid, single-cycle pulse even if valid is held
      @(posedge clk); #1;
      bus.iomem_addr  = {27'd0, 3'(REG_STATUS), 2'b00};
      bus.iomem_wstrb = 4'h0;
      bus.iomem_valid = 1'b1;
      @(posedge clk); #1;
      chk("ack_lat", {31'd0, bus.iomem_ready}, 32'd1);
      chk("rst_status", bus.iomem_rdata, 32'h0000_0005);
      @(posedge clk); #1;
      chk("ack_pulse", {31'd0, bus.iomem_ready}, 32'd0);
      bus.iomem_valid = 1'b0;
      rd_chk("rst_ctrl", REG_CTRL, 32'h0);
      rd_chk("unmapped", 3'd5, 32'h0);

      // stream to core, including a partial-strobe write taken as a full word
      m_ready = 1'b1;
      wr(REG_CTRL, 32'h1);
      wr_din(32'hDEAD_BEEF);
      wr_din(32'h1234_5678, 4'b0010);
      repeat (4) @(posedge clk);
      #1 chk("m_drain", mq.size(), 32'd0);
      chk("m_idle", {31'd0, m_valid}, 32'd0);

      // overflow with the stream frozen
      m_ready = 1'b0;
      wr(REG_CTRL, 32'h0);
      for (int i = 0; i < 8; i++) wr_din(32'h100 + i);
      wr(REG_DIN, 32'hBAD0_0BAD);
      rd_chk("in_full_st", REG_STATUS, 32'h0000_0806);
      rd_chk("ovf_set", REG_IRQSTAT, 32'h1);
      wr(REG_IRQSTAT, 32'h1);
      rd_chk("ovf_w1c", REG_IRQSTAT, 32'h0);
      m_ready = 1'b1;
      wr(REG_CTRL, 32'h1);
      repeat (12) @(posedge clk);
      #1 chk("in_drain", mq.size(), 32'd0);
      rd_chk("in_empty_st", REG_STATUS, 32'h0000_0005);

      // result stream and interrupt timing
      m_ready = 1'b0;
      wr(REG_CTRL, 32'h5);
      s_fix = 32'hA5A5_0001;
      s_valid = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk) chk("irq_lat0", {31'd0, irq}, 32'd0);
      @(negedge clk) chk("irq_rise", {31'd0, irq}, 32'd1);
      rd_chk("dout_first", REG_DOUT, oq.pop_front());
      @(posedge clk); #1 chk("irq_fall", {31'd0, irq}, 32'd0);

      // underflow, then CLR with both FIFOs partly filled
      rd_chk("dout_empty", REG_DOUT, 32'h0);
      rd_chk("udf_set", REG_IRQSTAT, 32'h2);
      chk("irq_udf", {31'd0, irq}, 32'd1);
      wr(REG_DIN, 32'h11);
      wr(REG_DIN, 32'h22);
      s_fix = 32'h33;
      s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 s_valid = 1'b0;
      rd_chk("part_st", REG_STATUS, 32'h0003_0200);
      wr(REG_CTRL, 32'h3);
      oq.delete();
      rd_chk("clr_st", REG_STATUS, 32'h0000_0005);
      rd_chk("clr_irqst", REG_IRQSTAT, 32'h0);
      rd_chk("clr_ctrl", REG_CTRL, 32'h1);

      // out-FIFO full with the core still pushing while the CPU pops
      s_auto = 1'b1;
      s_valid = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("full_sready", {31'd0, s_ready}, 32'd0);
      rd_chk("out_full_st", REG_STATUS, 32'h0008_0009);
      for (int i = 0; i < 3; i++) rd_chk("dout_full", REG_DOUT, oq.pop_front());
      @(posedge clk); #1;
      rd_chk("out_refill_st", REG_STATUS, 32'h0008_0009);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("oq_level", oq.size(), 32'd8);
      for (int i = 0; i < 8; i++) rd_chk("dout_drain", REG_DOUT, oq.pop_front());
      rd_chk("final_st", REG_STATUS, 32'h0000_0005);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
